id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection.
//  Captures decoded operands/controls, selects forwarded values, drives ALU in1/in2/ALUCtl/Sign.
//  Raises stall_id to hold PC and IF/ID; inserts bubbles on stall and on branch/jump flush.
// PARAMETERS
//  DW    32  datapath width
//  RAW    5  register-address width; register 0 is hard-wired zero
//  CW     5  ALU control width
// PORTS
//  clk              in   1    clock, rising edge
//  rst_n            in   1    asynchronous active-low reset
//  flush            in   1    kill the instruction entering EX (branch/jump resolved)
//  id_valid         in   1    ID holds a real instruction
//  id_rs_addr       in   RAW  source A register address
//  id_rt_addr       in   RAW  source B register address
//  id_rs_data       in   DW   register-file read A (write-through already applied)
//  id_rt_data       in   DW   register-file read B
//  id_imm           in   DW   sign/zero-extended immediate
//  id_shamt         in   5    shift amount field
//  id_src_imm       in   1    in2 = immediate
//  id_src_shamt     in   1    in1 = {27'b0, shamt}
//  id_alu_ctl       in   CW   ALU operation code
//  id_sign          in   1    signed compare
//  id_wr_addr       in   RAW  destination register
//  id_reg_write     in   1    writes register file
//  id_mem_read      in   1    load
//  id_mem_write     in   1    store
//  exmem_wr_addr    in   RAW  EX/MEM destination;  exmem_reg_write in 1;  exmem_result in DW
//  memwb_wr_addr    in   RAW  MEM/WB destination;  memwb_reg_write in 1;  memwb_result in DW
//  stall_id         out  1    hold PC and IF/ID this cycle
//  ex_valid         out  1    EX holds a real instruction
//  ex_in1 / ex_in2  out  DW   ALU operands (forwarded, combinational from the pipeline register)
//  ex_alu_ctl       out  CW   to ALU ALUCtl;  ex_sign out 1  to ALU Sign
//  ex_store_data    out  DW   forwarded rt value for stores
//  ex_wr_addr       out  RAW  destination register
//  ex_reg_write, ex_mem_read, ex_mem_write   out 1 each
// BEHAVIOUR
//  Reset (async, rst_n=0): all registered fields 0 -> ex_valid=0, ex_alu_ctl=0, controls 0, stall_id=0.
//  Register update each edge, priority flush > stall > load:
//   flush    -> bubble: valid and all write/mem controls 0, data fields don't-care but held 0.
//   stall_id -> bubble into EX, ID contents retained upstream.
//   else     -> capture id_*; ex_valid=id_valid, controls gated by id_valid.
//  Bubble = ALUCtl 0 (AND), no register/memory side effects.
//  Load-use hazard (comb.): id_valid & ex_valid & ex_mem_read & ex_wr_addr!=0 &
//   (ex_wr_addr==id_rs_addr | ex_wr_addr==id_rt_addr). stall_id forced 0 while flush=1.
//  Forwarding (per source A/B, comb. in EX): EX/MEM match > MEM/WB match > registered data.
//   Match = *_reg_write & *_wr_addr!=0 & *_wr_addr==ex_rs/rt. Address 0 never forwards.
//  ex_in1 = src_shamt ? {27'b0, shamt} : fwdA.  ex_in2 = src_imm ? imm : fwdB.  ex_store_data = fwdB.
//  Latency: one cycle from ID capture to ALU operands; stall lasts exactly one cycle per load-use.
//  Reset mid-stall: stall_id drops immediately with rst_n=0; no instruction survives.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding as above; only load-use stalls.
//  ID_EX_FWD_EN undefined: no forwarding muxes (fwdA/fwdB = registered data); stall_id also
//   asserted on any RAW match of id_rs/id_rt against EX stage (ex_reg_write) or EX/MEM
//   (exmem_reg_write); MEM/WB is covered by register-file write-through. Ports unchanged.
// STRUCTURE
//  Shared package cpu_pkg: DW/RAW/CW constants, ALUCtl encodings (AND=5'b00000 ... MUL=5'b11010),
//   forward-select enum {FWD_REG, FWD_EXMEM, FWD_MEMWB}.
//  One sub-module: fwd_mux (one instance per source; address compare + 3:1 select).
// TESTING
//  1 add $3,$1,$2 then sub $4,$3,$1 (FWD on): ex_in1 = exmem_result, no stall, result ready next cycle.
//  2 lw $5 then add $6,$5,$5: stall_id=1 for exactly one cycle, bubble ex_valid=0, then both operands from MEM/WB.
//  3 exmem and memwb both write $7 (0x11 / 0x22): ex_in1=0x00000011 (EX/MEM priority).
//  4 Writer to $0 with exmem_result=0xDEADBEEF: consumer of $0 sees 0, no stall.
//  5 flush and load-use same cycle: stall_id=0, EX gets bubble, no reg/mem write.
//  6 FWD off, add $3 then sub $4,$3: stall 2 cycles, operand equals write-through value.
//  Also: sll with shamt=4 -> ex_in1=0x00000004; assert rst_n low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU control encodings and forward-select enum.
// Used by id_ex_stage (whose forwarding is built only when ID_EX_FWD_EN is defined).
package cpu_pkg;

  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int CW  = 5;

  localparam logic [CW-1:0] ALU_AND = 5'b00000;
  localparam logic [CW-1:0] ALU_OR  = 5'b00001;
  localparam logic [CW-1:0] ALU_ADD = 5'b00010;
  localparam logic [CW-1:0] ALU_SUB = 5'b00110;
  localparam logic [CW-1:0] ALU_SLT = 5'b00111;
  localparam logic [CW-1:0] ALU_NOR = 5'b01100;
  localparam logic [CW-1:0] ALU_XOR = 5'b01101;
  localparam logic [CW-1:0] ALU_SLL = 5'b10000;
  localparam logic [CW-1:0] ALU_SRL = 5'b10001;
  localparam logic [CW-1:0] ALU_SRA = 5'b10010;
  localparam logic [CW-1:0] ALU_MUL = 5'b11010;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, later pipeline stages and the ID/EX stage.
// master = surrounding pipeline (drives ID/bypass sources), slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int DW  = cpu_pkg::DW,
  parameter int RAW = cpu_pkg::RAW,
  parameter int CW  = cpu_pkg::CW
);
  logic           flush;
  logic           id_valid;
  logic [RAW-1:0] id_rs_addr;
  logic [RAW-1:0] id_rt_addr;
  logic [DW-1:0]  id_rs_data;
  logic [DW-1:0]  id_rt_data;
  logic [DW-1:0]  id_imm;
  logic [4:0]     id_shamt;
  logic           id_src_imm;
  logic           id_src_shamt;
  logic [CW-1:0]  id_alu_ctl;
  logic           id_sign;
  logic [RAW-1:0] id_wr_addr;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           id_mem_write;

  logic [RAW-1:0] exmem_wr_addr;
  logic           exmem_reg_write;
  logic [DW-1:0]  exmem_result;
  logic [RAW-1:0] memwb_wr_addr;
  logic           memwb_reg_write;
  logic [DW-1:0]  memwb_result;

  logic           stall_id;
  logic           ex_valid;
  logic [DW-1:0]  ex_in1;
  logic [DW-1:0]  ex_in2;
  logic [CW-1:0]  ex_alu_ctl;
  logic           ex_sign;
  logic [DW-1:0]  ex_store_data;
  logic [RAW-1:0] ex_wr_addr;
  logic           ex_reg_write;
  logic           ex_mem_read;
  logic           ex_mem_write;

  modport master (
    output flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_src_imm, id_src_shamt, id_alu_ctl, id_sign, id_wr_addr,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_wr_addr, exmem_reg_write, exmem_result,
           memwb_wr_addr, memwb_reg_write, memwb_result,
    input  stall_id, ex_valid, ex_in1, ex_in2, ex_alu_ctl, ex_sign, ex_store_data,
           ex_wr_addr, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  flush, id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
           id_shamt, id_src_imm, id_src_shamt, id_alu_ctl, id_sign, id_wr_addr,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_wr_addr, exmem_reg_write, exmem_result,
           memwb_wr_addr, memwb_reg_write, memwb_result,
    output stall_id, ex_valid, ex_in1, ex_in2, ex_alu_ctl, ex_sign, ex_store_data,
           ex_wr_addr, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One EX-side operand bypass: EX/MEM result beats MEM/WB result beats the registered
// register-file value; destination register 0 never forwards.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW  = cpu_pkg::DW,
  parameter int RAW = cpu_pkg::RAW
) (
  input  logic [RAW-1:0] src_addr,
  input  logic [DW-1:0]  reg_data,
  input  logic [RAW-1:0] exmem_wr_addr,
  input  logic           exmem_reg_write,
  input  logic [DW-1:0]  exmem_result,
  input  logic [RAW-1:0] memwb_wr_addr,
  input  logic           memwb_reg_write,
  input  logic [DW-1:0]  memwb_result,
  output logic [DW-1:0]  fwd_data
);

  fwd_sel_e sel;
  logic     exmem_hit;
  logic     memwb_hit;

  always_comb begin
    exmem_hit = exmem_reg_write && (exmem_wr_addr != '0) && (exmem_wr_addr == src_addr);
    memwb_hit = memwb_reg_write && (memwb_wr_addr != '0) && (memwb_wr_addr == src_addr);
    sel = FWD_REG;
    if (exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    unique case (sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      default:   fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection and ID stall generation.
// ID_EX_FWD_EN defined: bypass muxes + load-use stall; undefined: stall on any EX/EX-MEM RAW.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW  = cpu_pkg::DW,
  parameter int RAW = cpu_pkg::RAW,
  parameter int CW  = cpu_pkg::CW
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic           valid;
`ifdef ID_EX_FWD_EN
    logic [RAW-1:0] rs_addr;
    logic [RAW-1:0] rt_addr;
`endif
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [DW-1:0]  imm;
    logic [4:0]     shamt;
    logic           src_imm;
    logic           src_shamt;
    logic [CW-1:0]  alu_ctl;
    logic           sign;
    logic [RAW-1:0] wr_addr;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;

  logic stall_d;
  logic ex_hit;
  logic hazard;

  // Register 0 is never a real producer, so it can neither stall nor forward.
  always_comb begin
    ex_hit = (ex_q.wr_addr != '0) &&
             ((ex_q.wr_addr == bus.id_rs_addr) || (ex_q.wr_addr == bus.id_rt_addr));
`ifdef ID_EX_FWD_EN
    hazard = ex_q.valid && ex_q.mem_read && ex_hit;
`else
    hazard = (ex_q.reg_write && ex_hit) ||
             (bus.exmem_reg_write && (bus.exmem_wr_addr != '0) &&
              ((bus.exmem_wr_addr == bus.id_rs_addr) || (bus.exmem_wr_addr == bus.id_rt_addr)));
`endif
    // rst_n gating makes the stall drop immediately when reset asserts mid-stall.
    stall_d = rst_n && bus.id_valid && !bus.flush && hazard;
  end

  always_comb begin
    ex_d = '0;
    if (!bus.flush && !stall_d) begin
      ex_d.valid     = bus.id_valid;
`ifdef ID_EX_FWD_EN
      ex_d.rs_addr   = bus.id_rs_addr;
      ex_d.rt_addr   = bus.id_rt_addr;
`endif
      ex_d.rs_data   = bus.id_rs_data;
      ex_d.rt_data   = bus.id_rt_data;
      ex_d.imm       = bus.id_imm;
      ex_d.shamt     = bus.id_shamt;
      ex_d.src_imm   = bus.id_src_imm;
      ex_d.src_shamt = bus.id_src_shamt;
      ex_d.wr_addr   = bus.id_wr_addr;
      ex_d.alu_ctl   = bus.id_valid ? bus.id_alu_ctl : ALU_AND;
      ex_d.sign      = bus.id_valid && bus.id_sign;
      ex_d.reg_write = bus.id_valid && bus.id_reg_write;
      ex_d.mem_read  = bus.id_valid && bus.id_mem_read;
      ex_d.mem_write = bus.id_valid && bus.id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  logic [DW-1:0] src_data [2];
  logic [DW-1:0] fwd_data [2];

  assign src_data[0] = ex_q.rs_data;
  assign src_data[1] = ex_q.rt_data;

`ifdef ID_EX_FWD_EN
  logic [RAW-1:0] src_addr [2];
  assign src_addr[0] = ex_q.rs_addr;
  assign src_addr[1] = ex_q.rt_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_mux (
      .src_addr        (src_addr[gi]),
      .reg_data        (src_data[gi]),
      .exmem_wr_addr   (bus.exmem_wr_addr),
      .exmem_reg_write (bus.exmem_reg_write),
      .exmem_result    (bus.exmem_result),
      .memwb_wr_addr   (bus.memwb_wr_addr),
      .memwb_reg_write (bus.memwb_reg_write),
      .memwb_result    (bus.memwb_result),
      .fwd_data        (fwd_data[gi])
    );
  end
`else
  for (genvar gi = 0; gi < 2; gi++) begin : g_nofwd
    assign fwd_data[gi] = src_data[gi];
  end
`endif

  assign bus.stall_id      = stall_d;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_in1        = ex_q.src_shamt ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_data[0];
  assign bus.ex_in2        = ex_q.src_imm ? ex_q.imm : fwd_data[1];
  assign bus.ex_store_data = fwd_data[1];
  assign bus.ex_alu_ctl    = ex_q.alu_ctl;
  assign bus.ex_sign       = ex_q.sign;
  assign bus.ex_wr_addr    = ex_q.wr_addr;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed per-cycle vector table, reset-mid-stall sequence and
// randomized run against a behavioural model; expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic flush, valid;
    logic [4:0] rs, rt, shamt, ctl, wr;
    logic [31:0] rsd, rtd, imm;
    logic si, ss, sign, rw, mr, mw;
    logic [4:0] xw; logic xwe; logic [31:0] xres;
    logic [4:0] ww; logic wwe; logic [31:0] wres;
    logic e_stall, e_valid;
    logic [31:0] e_in1, e_in2, e_st;
    logic [4:0] e_ctl;
    logic e_rw, e_mr, e_mw;
  } vec_t;

  vec_t cur;
  vec_t vq[$];

  task automatic row(input logic flush);
    cur = '{default: '0};
    cur.flush = flush;
  endtask

  task automatic id_i(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                      input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] shamt,
                      input logic si, input logic ss, input logic [4:0] ctl, input logic [4:0] wr,
                      input logic rw, input logic mr, input logic mw);
    cur.valid = 1'b1; cur.rs = rs; cur.rsd = rsd; cur.rt = rt; cur.rtd = rtd;
    cur.imm = imm; cur.shamt = shamt; cur.si = si; cur.ss = ss; cur.ctl = ctl;
    cur.wr = wr; cur.rw = rw; cur.mr = mr; cur.mw = mw;
  endtask

  task automatic fw(input logic [4:0] xw, input logic xwe, input logic [31:0] xres,
                    input logic [4:0] ww, input logic wwe, input logic [31:0] wres);
    cur.xw = xw; cur.xwe = xwe; cur.xres = xres;
    cur.ww = ww; cur.wwe = wwe; cur.wres = wres;
  endtask

  task automatic ex_o(input logic stall, input logic valid, input logic [31:0] in1,
                      input logic [31:0] in2, input logic [31:0] st, input logic [4:0] ctl,
                      input logic rw, input logic mr, input logic mw);
    cur.e_stall = stall; cur.e_valid = valid; cur.e_in1 = in1; cur.e_in2 = in2;
    cur.e_st = st; cur.e_ctl = ctl; cur.e_rw = rw; cur.e_mr = mr; cur.e_mw = mw;
    vq.push_back(cur);
  endtask

  task automatic drive(input vec_t v);
    bus.flush = v.flush;          bus.id_valid = v.valid;
    bus.id_rs_addr = v.rs;        bus.id_rt_addr = v.rt;
    bus.id_rs_data = v.rsd;       bus.id_rt_data = v.rtd;
    bus.id_imm = v.imm;           bus.id_shamt = v.shamt;
    bus.id_src_imm = v.si;        bus.id_src_shamt = v.ss;
    bus.id_alu_ctl = v.ctl;       bus.id_sign = v.sign;
    bus.id_wr_addr = v.wr;        bus.id_reg_write = v.rw;
    bus.id_mem_read = v.mr;       bus.id_mem_write = v.mw;
    bus.exmem_wr_addr = v.xw;     bus.exmem_reg_write = v.xwe;  bus.exmem_result = v.xres;
    bus.memwb_wr_addr = v.ww;     bus.memwb_reg_write = v.wwe;  bus.memwb_result = v.wres;
  endtask

  task automatic build_table();
    logic [31:0] st_fwd;
`ifdef ID_EX_FWD_EN
    st_fwd = 32'h77;
    row(0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(1, 10, 2, 20, 0, 0, 0, 0, ALU_ADD, 3, 1, 0, 0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(3, 'h99, 1, 10, 0, 0, 0, 0, ALU_SUB, 4, 1, 0, 0); ex_o(0, 1, 10, 20, 20, ALU_ADD, 1, 0, 0);
    row(0); id_i(1, 10, 0, 0, 4, 0, 1, 0, ALU_ADD, 5, 1, 1, 0); fw(3, 1, 30, 0, 0, 0);
            ex_o(0, 1, 30, 10, 10, ALU_SUB, 1, 0, 0);
    row(0); id_i(5, 0, 5, 0, 0, 0, 0, 0, ALU_ADD, 6, 1, 0, 0); fw(4, 1, 20, 3, 1, 30);
            ex_o(1, 1, 10, 4, 0, ALU_ADD, 1, 1, 0);
    row(0); id_i(5, 0, 5, 0, 0, 0, 0, 0, ALU_ADD, 6, 1, 0, 0); fw(5, 1, 14, 4, 1, 20);
            ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); fw(0, 0, 0, 5, 1, 'h55); ex_o(0, 1, 'h55, 'h55, 'h55, ALU_ADD, 1, 0, 0);
    row(0); id_i(7, 1, 0, 0, 0, 0, 0, 0, ALU_OR, 8, 1, 0, 0); fw(6, 1, 'hAA, 0, 0, 0);
            ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 9, 1, 0, 0); fw(7, 1, 'h11, 7, 1, 'h22);
            ex_o(0, 1, 'h11, 0, 0, ALU_OR, 1, 0, 0);
    row(0); id_i(1, 10, 0, 0, 8, 0, 1, 0, ALU_ADD, 0, 1, 1, 0); fw(0, 1, 'hDEADBEEF, 0, 1, 'hCAFEF00D);
            ex_o(0, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
    row(0); id_i(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 10, 1, 0, 0); ex_o(0, 1, 10, 8, 0, ALU_ADD, 1, 1, 0);
    row(0); id_i(1, 10, 0, 0, 0, 0, 1, 0, ALU_ADD, 11, 1, 1, 0); fw(0, 1, 'hDEADBEEF, 0, 0, 0);
            ex_o(0, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
    row(1); id_i(11, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 12, 1, 0, 0); ex_o(0, 1, 10, 0, 0, ALU_ADD, 1, 1, 0);
    row(0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
`else
    st_fwd = 32'd20;
    row(0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(1, 10, 2, 20, 0, 0, 0, 0, ALU_ADD, 3, 1, 0, 0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(3, 'h99, 1, 10, 0, 0, 0, 0, ALU_SUB, 4, 1, 0, 0); ex_o(1, 1, 10, 20, 20, ALU_ADD, 1, 0, 0);
    row(0); id_i(3, 'h99, 1, 10, 0, 0, 0, 0, ALU_SUB, 4, 1, 0, 0); fw(3, 1, 30, 0, 0, 0);
            ex_o(1, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(3, 30, 1, 10, 0, 0, 0, 0, ALU_SUB, 4, 1, 0, 0); fw(0, 0, 0, 3, 1, 30);
            ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); ex_o(0, 1, 30, 10, 10, ALU_SUB, 1, 0, 0);
    row(0); id_i(7, 1, 0, 0, 0, 0, 0, 0, ALU_OR, 8, 1, 0, 0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); fw(7, 1, 'h11, 7, 1, 'h22); ex_o(0, 1, 1, 0, 0, ALU_OR, 1, 0, 0);
    row(0); id_i(1, 10, 0, 0, 8, 0, 1, 0, ALU_ADD, 0, 1, 1, 0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); id_i(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 10, 1, 0, 0); fw(0, 1, 'hDEADBEEF, 0, 0, 0);
            ex_o(0, 1, 10, 8, 0, ALU_ADD, 1, 1, 0);
    row(1); id_i(10, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 12, 1, 0, 0); ex_o(0, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
    row(0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
`endif
    // sll ignores a forwarded rs; store data follows the (possibly forwarded) rt.
    row(0); id_i(31, 'hFFFFFFFF, 2, 20, 0, 4, 0, 1, ALU_SLL, 13, 1, 0, 0); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); fw(31, 1, 'h1234, 0, 0, 0); ex_o(0, 1, 4, 20, 20, ALU_SLL, 1, 0, 0);
    row(0); id_i(1, 10, 2, 20, 'h10, 0, 1, 0, ALU_ADD, 0, 0, 0, 1); ex_o(0, 0, 0, 0, 0, ALU_AND, 0, 0, 0);
    row(0); fw(2, 1, 'h77, 0, 0, 0); ex_o(0, 1, 10, 'h10, st_fwd, ALU_ADD, 0, 0, 1);
  endtask

  // Behavioural model of the EX slot.
  typedef struct {
    logic valid;
    logic [4:0] rs, rt, wr, shamt, ctl;
    logic [31:0] rsd, rtd, imm;
    logic si, ss, sign, rw, mr, mw;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] seen(input logic [4:0] a, input logic [31:0] d,
                                       input logic [4:0] xw, input logic xwe, input logic [31:0] xr,
                                       input logic [4:0] ww, input logic wwe, input logic [31:0] wr);
`ifdef ID_EX_FWD_EN
    if (a != 0 && xwe && xw == a) return xr;
    if (a != 0 && wwe && ww == a) return wr;
`endif
    return d;
  endfunction

  initial begin
    vec_t v;
    rst_n = 1'b0;
    v = '{default: '0};
    drive(v);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", bus.stall_id, 0);
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_ctl", bus.ex_alu_ctl, 0);
    chk("rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    build_table();
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("row%0d_stall", i), bus.stall_id, vq[i].e_stall);
      chk($sformatf("row%0d_valid", i), bus.ex_valid, vq[i].e_valid);
      chk($sformatf("row%0d_in1", i), bus.ex_in1, vq[i].e_in1);
      chk($sformatf("row%0d_in2", i), bus.ex_in2, vq[i].e_in2);
      chk($sformatf("row%0d_store", i), bus.ex_store_data, vq[i].e_st);
      chk($sformatf("row%0d_ctl", i), bus.ex_alu_ctl, vq[i].e_ctl);
      chk($sformatf("row%0d_rw", i), bus.ex_reg_write, vq[i].e_rw);
      chk($sformatf("row%0d_mr", i), bus.ex_mem_read, vq[i].e_mr);
      chk($sformatf("row%0d_mw", i), bus.ex_mem_write, vq[i].e_mw);
      $display("row %0d: stall=%0b valid=%0b in1=%08h in2=%08h st=%08h",
               i, bus.stall_id, bus.ex_valid, bus.ex_in1, bus.ex_in2, bus.ex_store_data);
    end

    // Reset asserted while a load-use stall is active.
    @(negedge clk);
    row(0); id_i(1, 10, 0, 0, 0, 0, 1, 0, ALU_ADD, 5, 1, 1, 0); drive(cur);
    @(negedge clk);
    row(0); id_i(5, 0, 5, 0, 0, 0, 0, 0, ALU_ADD, 6, 1, 0, 0); drive(cur);
    #1;
    chk("mid_stall_on", bus.stall_id, 1);
    chk("mid_stall_mr", bus.ex_mem_read, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", bus.stall_id, 0);
    chk("async_rst_valid", bus.ex_valid, 0);
    chk("async_rst_in1", bus.ex_in1, 0);
    chk("async_rst_in2", bus.ex_in2, 0);
    chk("async_rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 0);
    $display("reset mid-stall: stall=%0b valid=%0b", bus.stall_id, bus.ex_valid);
    @(negedge clk);
    v = '{default: '0};
    drive(v);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_valid", bus.ex_valid, 0);
    m = '{default: '0};

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic e_stall, hit_ex, hit_xm;
      logic [31:0] fa, fb, e_in1, e_in2;
      @(negedge clk);
      v = '{default: '0};
      v.flush = ($urandom_range(0, 7) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.rs = 5'($urandom_range(0, 3));  v.rt = 5'($urandom_range(0, 3));
      v.wr = 5'($urandom_range(0, 3));  v.shamt = 5'($urandom);  v.ctl = 5'($urandom);
      v.rsd = $urandom; v.rtd = $urandom; v.imm = $urandom;
      v.si = ($urandom_range(0, 3) == 0); v.ss = ($urandom_range(0, 3) == 0);
      v.sign = 1'($urandom); v.rw = 1'($urandom);
      v.mr = ($urandom_range(0, 2) == 0); v.mw = ($urandom_range(0, 4) == 0);
      v.xw = 5'($urandom_range(0, 3)); v.xwe = 1'($urandom); v.xres = $urandom;
      v.ww = 5'($urandom_range(0, 3)); v.wwe = 1'($urandom); v.wres = $urandom;
      drive(v);
      #1;
      hit_ex = (m.wr != 0) && (m.wr == v.rs || m.wr == v.rt);
      hit_xm = v.xwe && (v.xw != 0) && (v.xw == v.rs || v.xw == v.rt);
`ifdef ID_EX_FWD_EN
      e_stall = v.valid && !v.flush && m.valid && m.mr && hit_ex;
`else
      e_stall = v.valid && !v.flush && ((m.rw && hit_ex) || hit_xm);
`endif
      fa = seen(m.rs, m.rsd, v.xw, v.xwe, v.xres, v.ww, v.wwe, v.wres);
      fb = seen(m.rt, m.rtd, v.xw, v.xwe, v.xres, v.ww, v.wwe, v.wres);
      e_in1 = m.ss ? {27'd0, m.shamt} : fa;
      e_in2 = m.si ? m.imm : fb;
      chk($sformatf("rnd%0d_stall", c), bus.stall_id, e_stall);
      chk($sformatf("rnd%0d_valid", c), bus.ex_valid, m.valid);
      chk($sformatf("rnd%0d_in1", c), bus.ex_in1, e_in1);
      chk($sformatf("rnd%0d_in2", c), bus.ex_in2, e_in2);
      chk($sformatf("rnd%0d_store", c), bus.ex_store_data, fb);
      chk($sformatf("rnd%0d_ctl", c), bus.ex_alu_ctl, m.ctl);
      chk($sformatf("rnd%0d_wr", c), bus.ex_wr_addr, m.wr);
      chk($sformatf("rnd%0d_ctrl", c), {bus.ex_sign, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
          {m.sign, m.rw, m.mr, m.mw});
      $display("rnd %0d: flush=%0b stall=%0b in1=%08h in2=%08h", c, v.flush, bus.stall_id,
               bus.ex_in1, bus.ex_in2);
      @(posedge clk);
      if (v.flush || e_stall) begin
        m = '{default: '0};
      end else begin
        m.valid = v.valid; m.rs = v.rs; m.rt = v.rt; m.wr = v.wr; m.shamt = v.shamt;
        m.rsd = v.rsd; m.rtd = v.rtd; m.imm = v.imm; m.si = v.si; m.ss = v.ss;
        m.ctl  = v.valid ? v.ctl : 5'd0;
        m.sign = v.valid && v.sign;
        m.rw   = v.valid && v.rw;
        m.mr   = v.valid && v.mr;
        m.mw   = v.valid && v.mw;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
